// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared vectors, redirect-source encoding and jump-target helper for the fetch stage
package pipeline_pkg;
    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;

    typedef enum logic [2:0] {RS_SEQ, RS_BR, RS_JMP, RS_JR, RS_IRQ, RS_EXC} redirect_src_e;

    // Low 28 bits of a J/JAL target; the caller supplies the upper PC region bits
    function automatic logic [27:0] jump_low(input logic [25:0] index);
        return {index, 2'b00};
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, instr}; flush beats push, a popped head is still valid that cycle
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_q + AW'(pop_i);
            wr_q    <= wr_q + AW'(push_i);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/pipeline_fetch_unit.sv
// pipeline_fetch_unit: PC register, redirect arbitration and credit-based prefetch into a small queue
module pipeline_fetch_unit
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(RESET_VEC_DEF),
    parameter logic [ADDR_W-1:0] IRQ_VEC    = ADDR_W'(IRQ_VEC_DEF),
    parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(EXC_VEC_DEF),
    parameter int                FQ_DEPTH   = 4,
    parameter int                KERNEL_BIT = 31
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_rdata_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              jmp_valid_i,
    input  logic [ADDR_W-1:0] jmp_pc4_i,
    input  logic [25:0]       jmp_index_i,
    input  logic              jr_valid_i,
    input  logic [ADDR_W-1:0] jr_target_i,
    input  logic              irq_i,
    input  logic              exc_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [31:0]       id_instr_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [ADDR_W-1:0] id_pc_plus4_o,
    output logic              irq_ack_o,
    output logic [ADDR_W-1:0] epc_o
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam int QW = ADDR_W + 32;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, pend_pc_q, pend_pc_d, target;
    logic              pending_q, pending_d, irq_en, redirect, push, pop;
    logic [CW-1:0]     count;
    logic [QW-1:0]     head;
    redirect_src_e     src;

    always_comb begin
        irq_en   = irq_i && !exc_i && !fetch_pc_q[KERNEL_BIT];
        src      = exc_i       ? RS_EXC :
                   irq_en      ? RS_IRQ :
                   jr_valid_i  ? RS_JR  :
                   jmp_valid_i ? RS_JMP :
                   br_taken_i  ? RS_BR  : RS_SEQ;
        redirect = src != RS_SEQ;
        target   = src == RS_EXC ? EXC_VEC :
                   src == RS_IRQ ? IRQ_VEC :
                   src == RS_JR  ? jr_target_i :
                   src == RS_JMP ? {jmp_pc4_i[ADDR_W-1:28], jump_low(jmp_index_i)} : br_target_i;
        target[1:0] = 2'b00;
        // Outstanding request holds a queue slot so the response can never overflow it
        imem_req_o = rst_ni && !redirect && (count + CW'(pending_q) < CW'(FQ_DEPTH));
        push       = pending_q && !redirect;
        pop        = id_valid_o && id_ready_i;
        fetch_pc_d = redirect ? target : imem_req_o ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
        pending_d  = imem_req_o;
        pend_pc_d  = imem_req_o ? fetch_pc_q : pend_pc_q;
    end

    fetch_queue #(.WIDTH(QW), .DEPTH(FQ_DEPTH)) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  ({pend_pc_q, imem_rdata_i}),
        .pop_i   (pop),
        .flush_i (redirect),
        .count_o (count),
        .head_o  (head)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_VEC;
            pend_pc_q  <= RESET_VEC;
            pending_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            pending_q  <= pending_d;
        end
    end

    assign imem_addr_o   = fetch_pc_q;
    assign id_valid_o    = count != '0;
    assign id_instr_o    = head[31:0];
    assign id_pc_o       = head[QW-1:32];
    assign id_pc_plus4_o = head[QW-1:32] + ADDR_W'(4);
    assign irq_ack_o     = rst_ni && src == RS_IRQ;
    assign epc_o         = id_valid_o ? head[QW-1:32] : pending_q ? pend_pc_q : fetch_pc_q;
endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// tb_pipeline_fetch_unit: directed vectors with hand-computed expectations for the fetch stage
module tb_pipeline_fetch_unit;
    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o, imem_rdata_i = '0;
    logic        br_taken_i = 0, jmp_valid_i = 0, jr_valid_i = 0, irq_i = 0, exc_i = 0;
    logic [31:0] br_target_i = '0, jmp_pc4_i = '0, jr_target_i = '0;
    logic [25:0] jmp_index_i = '0;
    logic        id_valid_o, id_ready_i = 1'b0, irq_ack_o;
    logic [31:0] id_instr_o, id_pc_o, id_pc_plus4_o, epc_o;
    int total = 0, bad = 0;

    pipeline_fetch_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imem_rdata_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .jmp_valid_i(jmp_valid_i), .jmp_pc4_i(jmp_pc4_i), .jmp_index_i(jmp_index_i),
        .jr_valid_i(jr_valid_i), .jr_target_i(jr_target_i), .irq_i(irq_i), .exc_i(exc_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o),
        .id_pc_plus4_o(id_pc_plus4_o), .irq_ack_o(irq_ack_o), .epc_o(epc_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory with 1-cycle latency that returns the address as data
    always @(posedge clk_i) imem_rdata_i <= imem_addr_o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_req", imem_req_o, 0);
        check("rst_valid", id_valid_o, 0);
        check("rst_ack", irq_ack_o, 0);
        check("rst_epc", epc_o, 32'h8000_0000);
        rst_ni = 1'b1;
        #1;
        check("c0_req", imem_req_o, 1);
        check("c0_addr", imem_addr_o, 32'h8000_0000);
        step;
        check("c1_addr", imem_addr_o, 32'h8000_0004);
        check("c1_valid", id_valid_o, 0);
        step;
        check("c2_valid", id_valid_o, 1);
        check("c2_pc", id_pc_o, 32'h8000_0000);
        check("c2_pc4", id_pc_plus4_o, 32'h8000_0004);
        check("c2_instr", id_instr_o, 32'h8000_0000);
        check("c2_addr", imem_addr_o, 32'h8000_0008);
        check("c2_epc", epc_o, 32'h8000_0000);
        step;
        check("c3_req", imem_req_o, 1);
        check("c3_addr", imem_addr_o, 32'h8000_000C);
        step;
        check("c4_req_stall", imem_req_o, 0);
        step;
        check("c5_req_stall", imem_req_o, 0);
        check("c5_pc_hold", id_pc_o, 32'h8000_0000);
        id_ready_i = 1'b1;
        step;
        id_ready_i = 1'b0;
        #1;
        check("c6_req", imem_req_o, 1);
        check("c6_addr", imem_addr_o, 32'h8000_0010);
        check("c6_pc", id_pc_o, 32'h8000_0004);
        step;
        check("c7_req_stall", imem_req_o, 0);
        br_taken_i = 1'b1; br_target_i = 32'h0040_0020;
        #1;
        check("br_req", imem_req_o, 0);
        check("br_epc", epc_o, 32'h8000_0004);
        step;
        br_taken_i = 1'b0;
        #1;
        check("br_flush", id_valid_o, 0);
        check("br_addr", imem_addr_o, 32'h0040_0020);
        step;
        check("br_drop", id_valid_o, 0);
        step;
        check("br_valid", id_valid_o, 1);
        check("br_pc", id_pc_o, 32'h0040_0020);
        check("br_instr", id_instr_o, 32'h0040_0020);
        jr_valid_i = 1'b1; jr_target_i = 32'h0040_0100;
        #1;
        check("jr_epc", epc_o, 32'h0040_0020);
        step;
        jr_valid_i = 1'b0; irq_i = 1'b1;
        #1;
        check("irq_ack", irq_ack_o, 1);
        check("irq_epc", epc_o, 32'h0040_0100);
        check("irq_req", imem_req_o, 0);
        step;
        check("irq_masked", irq_ack_o, 0);
        check("irq_addr", imem_addr_o, 32'h8000_0004);
        step;
        check("kern_seq", imem_addr_o, 32'h8000_0008);
        check("kern_ack", irq_ack_o, 0);
        irq_i = 1'b0; jmp_valid_i = 1'b1; jmp_pc4_i = 32'h1000_0008; jmp_index_i = 26'h000_0010;
        #1;
        check("jmp_req", imem_req_o, 0);
        step;
        jmp_valid_i = 1'b0;
        #1;
        check("jmp_addr", imem_addr_o, 32'h1000_0040);
        exc_i = 1'b1; irq_i = 1'b1; jr_valid_i = 1'b1; jr_target_i = 32'h0040_0200;
        #1;
        check("exc_ack", irq_ack_o, 0);
        step;
        exc_i = 1'b0; irq_i = 1'b0; jr_valid_i = 1'b0;
        #1;
        check("exc_addr", imem_addr_o, 32'h8000_0008);
        br_taken_i = 1'b1; br_target_i = 32'h0040_0033;
        #1;
        step;
        br_taken_i = 1'b0;
        #1;
        check("misalign", imem_addr_o, 32'h0040_0030);
        irq_i = 1'b1; jr_valid_i = 1'b1; jr_target_i = 32'h0040_0200;
        #1;
        check("irq_over_jr", irq_ack_o, 1);
        step;
        irq_i = 1'b0; jr_valid_i = 1'b0;
        #1;
        check("irq_addr2", imem_addr_o, 32'h8000_0004);
        jr_valid_i = 1'b1; jr_target_i = 32'hFFFF_FFFC;
        step;
        jr_valid_i = 1'b0;
        #1;
        check("wrap_hi", imem_addr_o, 32'hFFFF_FFFC);
        step;
        check("wrap_lo", imem_addr_o, 32'h0000_0000);
        check("wrap_req", imem_req_o, 1);
        id_ready_i = 1'b1;
        step;
        check("wrap_valid", id_valid_o, 1);
        check("wrap_pc", id_pc_o, 32'hFFFF_FFFC);
        check("wrap_pc4", id_pc_plus4_o, 32'h0000_0000);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_req", imem_req_o, 0);
        check("arst_valid", id_valid_o, 0);
        check("arst_addr", imem_addr_o, 32'h8000_0000);
        repeat (2) step;
        rst_ni = 1'b1;
        #1;
        check("rs_req", imem_req_o, 1);
        check("rs_addr", imem_addr_o, 32'h8000_0000);
        repeat (2) step;
        check("rs_valid", id_valid_o, 1);
        check("rs_pc", id_pc_o, 32'h8000_0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
